soc_system_gpio_in_capture: RTL and testbench

//  Parametrised multi-channel input PIO on the HPS lightweight Avalon-MM bus; next generation of the single-bit edge-capture PIO.

---
 rtl/soc_system_pio_pkg.sv | 13 +
 rtl/soc_system_pio_debounce.sv | 58 +++++
 rtl/soc_system_gpio_in_capture.sv | 84 ++++++++
 tb/tb_soc_system_gpio_in_capture.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/soc_system_pio_pkg.sv
// Shared definitions for the input PIO family: register word addresses and edge-select encodings.
package soc_system_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RAW     = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/soc_system_pio_debounce.sv
// One input bit: 2-flop synchroniser plus optional stability filter; stable after 3 cycles (bypass) or 2+DEBOUNCE_CYCLES.
// No backpressure: free-running, one sample per clk.
module soc_system_pio_debounce #(
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic raw,
  output logic dout
);

  logic sync1;
  logic sync2;
  logic stable;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      always_ff @(posedge clk) begin
        if (!reset_n) stable <= 1'b0;
        else          stable <= sync2;
      end
    end else begin : g_filter
      localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
      logic [CW-1:0] cnt;

      // Counter only advances while sync2 disagrees, so it clears before it could wrap.
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          cnt    <= '0;
          stable <= 1'b0;
        end else if (sync2 == stable) begin
          cnt <= '0;
        end else if (cnt == LAST) begin
          stable <= sync2;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  endgenerate

  assign raw  = sync2;
  assign dout = stable;

endmodule

// File: rtl/soc_system_gpio_in_capture.sv
// Multi-channel input PIO: debounced inputs, sticky edge capture (RW1C), maskable level irq; 1-cycle registered reads.
// No backpressure: Avalon slave with fixed read latency and zero wait states.
module soc_system_gpio_in_capture
  import soc_system_pio_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int EDGE_MODE       = 0,
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] clr;
  logic [31:0]      rd_mux;
  logic             wr;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    soc_system_pio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (in_port[i]),
      .raw     (raw[i]),
      .dout    (stable[i])
    );
  end

  assign wr           = chipselect & ~write_n;
  assign clr          = (wr && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;
  assign unused_wdata = ^writedata;

  always_comb begin
    edge_det = stable & ~stable_d;
    case (EDGE_MODE)
      EDGE_FALLING: edge_det = ~stable & stable_d;
      EDGE_ANY:     edge_det = stable ^ stable_d;
      default:      edge_det = stable & ~stable_d;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:    rd_mux[WIDTH-1:0] = stable;
      ADDR_RAW:     rd_mux[WIDTH-1:0] = raw;
      ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irq_mask;
      default:      rd_mux[WIDTH-1:0] = edge_capture;
    endcase
  end

  // Set term is OR'd after the clear so a coincident edge is never lost.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stable_d     <= '0;
      irq_mask     <= '0;
      edge_capture <= '0;
      readdata     <= '0;
    end else begin
      stable_d     <= stable;
      edge_capture <= (edge_capture & ~clr) | edge_det;
      readdata     <= rd_mux;
      if (wr && address == ADDR_IRQMASK) irq_mask <= writedata[WIDTH-1:0];
    end
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_soc_system_gpio_in_capture.sv
// Three DUT flavours on one shared bus: A rising/bypass, B rising/debounce 10, C any-edge/bypass.
module tb_soc_system_gpio_in_capture;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_a, in_b, in_c;
  logic [31:0] rd_a, rd_b, rd_c;
  logic        irq_a, irq_b, irq_c;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  soc_system_gpio_in_capture #(.WIDTH(8), .EDGE_MODE(0), .DEBOUNCE_CYCLES(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_a), .readdata(rd_a), .irq(irq_a));

  soc_system_gpio_in_capture #(.WIDTH(8), .EDGE_MODE(0), .DEBOUNCE_CYCLES(10)) dut_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_b), .readdata(rd_b), .irq(irq_b));

  soc_system_gpio_in_capture #(.WIDTH(8), .EDGE_MODE(2), .DEBOUNCE_CYCLES(0)) dut_c (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_c), .readdata(rd_c), .irq(irq_c));

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL %s scoreboard empty, observed=0x%08h", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        failures++;
        $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
    end
  endtask

  task automatic chk_now(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    exp_q.push_back(exp);
    chk(tag, obs);
  endtask

  function automatic logic [31:0] pick_rd(input int which);
    if (which == 0) return rd_a;
    if (which == 1) return rd_b;
    return rd_c;
  endfunction

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
  endtask

  task automatic bus_read(input logic [1:0] a, input int which, input logic [31:0] exp, input string tag);
    address = a;
    exp_q.push_back(exp);
    tick();
    chk(tag, pick_rd(which));
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    in_a = 8'hFF; in_b = 8'hFF; in_c = 8'hFF;

    // Reset with pins held high
    tick(5);
    chk_now("rst_rd_a", rd_a, 32'h0);
    chk_now("rst_irq_a", {31'b0, irq_a}, 32'h0);
    chk_now("rst_rd_c", rd_c, 32'h0);
    reset_n = 1'b1;
    tick(15);
    chk_now("post_rst_data_a", rd_a, 32'h0000_00FF);
    chk_now("post_rst_data_b", rd_b, 32'h0000_00FF);
    chk_now("post_rst_data_c", rd_c, 32'h0000_00FF);
    chk_now("post_rst_irq_masked", {31'b0, irq_a}, 32'h0);
    bus_read(2'd3, 0, 32'h0000_00FF, "powerup_edgecap_a");
    bus_write(2'd3, 32'hFF);
    bus_read(2'd3, 0, 32'h0, "init_clear_a");

    // Rising capture, bypass: exactly 4 cycles to EDGECAP/irq
    bus_write(2'd2, 32'h1);
    in_a = 8'hFE;
    tick(6);
    bus_write(2'd3, 32'hFF);
    in_a = 8'hFF;
    tick(3);
    chk_now("rise_irq_cyc3", {31'b0, irq_a}, 32'h0);
    tick();
    chk_now("rise_irq_cyc4", {31'b0, irq_a}, 32'h1);
    tick();
    chk_now("rise_edgecap", rd_a, 32'h0000_0001);
    bus_write(2'd3, 32'h1);
    chk_now("w1c_irq_drop", {31'b0, irq_a}, 32'h0);
    in_a = 8'hFE;
    tick(8);
    chk_now("fall_ignored_cap", rd_a, 32'h0);
    chk_now("fall_ignored_irq", {31'b0, irq_a}, 32'h0);

    // W1C race: clear of bit 0 coincides with new edges on bits 0 and 1
    in_a = 8'hFC;
    tick(6);
    bus_write(2'd3, 32'hFF);
    in_a = 8'hFF;
    tick(3);
    bus_write(2'd3, 32'h1);
    bus_read(2'd3, 0, 32'h0000_0003, "race_set_wins");
    chk_now("race_irq", {31'b0, irq_a}, 32'h1);
    bus_write(2'd3, 32'h2);
    bus_read(2'd3, 0, 32'h0000_0001, "clear_bit1_only");

    // Debounce 10 on bit 3
    in_b = 8'hF7;
    tick(15);
    bus_write(2'd3, 32'hFF);
    bus_read(2'd0, 1, 32'h0000_00F7, "db_settled_low");
    in_b = 8'hFF;
    tick(9);
    in_b = 8'hF7;
    tick(15);
    bus_read(2'd0, 1, 32'h0000_00F7, "db_pulse9_data");
    bus_read(2'd3, 1, 32'h0, "db_pulse9_cap");
    address = 2'd0;
    in_b = 8'hFF;
    tick(10);
    in_b = 8'hF7;
    tick(2);
    chk_now("db_pulse10_cyc12", rd_b, 32'h0000_00F7);
    tick();
    chk_now("db_pulse10_cyc13", rd_b, 32'h0000_00FF);
    tick(15);
    bus_read(2'd3, 1, 32'h0000_0008, "db_pulse10_cap");
    in_b = 8'hFF;
    tick(3);
    bus_read(2'd1, 1, 32'h0000_00FF, "db_raw_leads");
    bus_read(2'd0, 1, 32'h0000_00F7, "db_data_lags");

    // Any-edge on bit 5 with irq masked
    bus_write(2'd2, 32'h0);
    in_c = 8'hDF;
    tick(6);
    bus_write(2'd3, 32'hFF);
    in_c = 8'hFF;
    tick(4);
    bus_read(2'd3, 2, 32'h0000_0020, "any_rise_cap");
    chk_now("any_rise_irq", {31'b0, irq_c}, 32'h0);
    bus_write(2'd3, 32'h20);
    bus_read(2'd3, 2, 32'h0, "any_cleared");
    in_c = 8'hDF;
    tick(5);
    bus_read(2'd3, 2, 32'h0000_0020, "any_fall_cap");
    chk_now("any_fall_irq", {31'b0, irq_c}, 32'h0);
    bus_write(2'd2, 32'h20);
    chk_now("unmask_irq", {31'b0, irq_c}, 32'h1);
    bus_write(2'd2, 32'h0);
    chk_now("remask_irq", {31'b0, irq_c}, 32'h0);
    bus_read(2'd3, 2, 32'h0000_0020, "mask_keeps_cap");

    // Address sweep on A
    bus_write(2'd0, 32'h0);
    bus_write(2'd1, 32'h0);
    bus_read(2'd0, 0, 32'h0000_00FF, "ro_data");
    bus_read(2'd1, 0, 32'h0000_00FF, "ro_raw");
    bus_write(2'd2, 32'hFFFF_FF5A);
    bus_read(2'd2, 0, 32'h0000_005A, "mask_upper_zero");
    address = 2'd0;
    #1;
    chk_now("rd_lag_before_edge", rd_a, 32'h0000_005A);
    tick();
    chk_now("rd_lag_after_edge", rd_a, 32'h0000_00FF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
